// File: rtl/out_mem_wr_sched.sv
// Write-side scheduler for the output result buffer: round-robin arbitration of
// N_REQ producers onto one write port, sequencing cfg_dat_num+1 beats per tile.
module out_mem_wr_sched #(
  parameter int WIDTH      = 256,
  parameter int N_REQ      = 4,
  parameter int log2_DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [log2_DEPTH-1:0]     cfg_dat_num,
  input  logic                      cfg_abort,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ*WIDTH-1:0]    req_dat,
  output logic [N_REQ-1:0]          req_rdy,
  output logic                      mem_dat_vld,
  output logic [WIDTH-1:0]          mem_dat,
  output logic [log2_DEPTH-1:0]     mem_dat_num,
  output logic                      busy,
  output logic                      tile_done,
  output logic [log2_DEPTH-1:0]     beat_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [log2_DEPTH-1:0] r_beat_cnt;
  logic [log2_DEPTH-1:0] r_dat_num;
  logic                  r_mem_vld;
  logic [WIDTH-1:0]      r_mem_dat;

  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [N_REQ-1:0]      w_gnt_oh;
  logic [WIDTH-1:0]      w_gnt_dat;

  // Round-robin search starting at r_ptr; abort suppresses any grant this cycle.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    if (r_state == S_RUN && !cfg_abort) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
        if (!w_gnt_any && req_vld[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_idx;
        end
      end
    end
  end

  assign w_gnt_oh  = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_gnt_dat = req_dat[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_dat_num  <= '0;
      r_mem_vld  <= 1'b0;
      r_mem_dat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_vld <= 1'b0;
          if (cfg_start && !cfg_abort) begin
            r_dat_num  <= cfg_dat_num;
            r_beat_cnt <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_abort) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_mem_vld  <= 1'b0;
          end else if (w_gnt_any) begin
            r_mem_vld <= 1'b1;
            r_mem_dat <= w_gnt_dat;
            r_ptr     <= w_ptr_nxt;
            if (r_beat_cnt == r_dat_num) begin
              r_state    <= S_DONE;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else begin
            r_mem_vld <= 1'b0;
          end
        end
        S_DONE: begin
          // Last beat is on the write port now; the tile closes unconditionally.
          r_state    <= S_IDLE;
          r_beat_cnt <= '0;
          r_mem_vld  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_vld <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy     = w_gnt_oh;
  assign mem_dat_vld = r_mem_vld;
  assign mem_dat     = r_mem_dat;
  assign mem_dat_num = r_dat_num;
  assign busy        = (r_state != S_IDLE);
  assign tile_done   = (r_state == S_DONE);
  assign beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_out_mem_wr_sched.sv
// Randomised and directed bench for out_mem_wr_sched, checked every cycle
// against a tile-level behavioural model plus literal grant-order expectations.
module tb_out_mem_wr_sched;

  localparam int W  = 256;
  localparam int N  = 4;
  localparam int LD = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start = 1'b0;
  logic [LD-1:0]   cfg_dat_num = '0;
  logic            cfg_abort = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N*W-1:0]  req_dat = '0;
  logic [N-1:0]    req_rdy;
  logic            mem_dat_vld;
  logic [W-1:0]    mem_dat;
  logic [LD-1:0]   mem_dat_num;
  logic            busy;
  logic            tile_done;
  logic [LD-1:0]   beat_cnt;

  out_mem_wr_sched #(.WIDTH(W), .N_REQ(N), .log2_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dat_num(cfg_dat_num),
    .cfg_abort(cfg_abort), .req_vld(req_vld), .req_dat(req_dat),
    .req_rdy(req_rdy), .mem_dat_vld(mem_dat_vld), .mem_dat(mem_dat),
    .mem_dat_num(mem_dat_num), .busy(busy), .tile_done(tile_done),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: phase 0 = idle, 1 = collecting beats, 2 = completion cycle.
  int            m_phase = 0;
  int            m_ptr   = 0;
  int            m_cnt   = 0;
  int            m_num   = 0;
  bit            m_vld   = 1'b0;
  logic [W-1:0]  m_dat   = '0;

  function automatic int pick();
    if (m_phase != 1 || cfg_abort) return -1;
    for (int k = 0; k < N; k++)
      if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0; m_num = 0; m_vld = 1'b0; m_dat = '0;
    end else begin
      g = pick();
      if (m_phase == 0) begin
        m_vld = 1'b0;
        if (cfg_start && !cfg_abort) begin
          m_num = int'(cfg_dat_num); m_cnt = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (cfg_abort) begin
          m_phase = 0; m_cnt = 0; m_vld = 1'b0;
        end else if (g >= 0) begin
          m_vld = 1'b1;
          m_dat = req_dat[g*W +: W];
          m_ptr = (g + 1) % N;
          if (m_cnt == m_num) begin m_phase = 2; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
        end else begin
          m_vld = 1'b0;
        end
      end else begin
        m_phase = 0; m_vld = 1'b0; m_cnt = 0;
      end
    end
  end

  int g_log[$];
  int n_vld  = 0;
  int n_done = 0;

  always @(negedge clk) begin
    int g;
    logic [N-1:0] e_rdy;
    g = pick();
    e_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_rdy", W'(req_rdy), W'(e_rdy));
    check("mem_dat_vld", W'(mem_dat_vld), W'(m_vld));
    check("mem_dat", mem_dat, m_dat);
    check("mem_dat_num", W'(mem_dat_num), W'(m_num));
    check("busy", W'(busy), W'(m_phase != 0));
    check("tile_done", W'(tile_done), W'(m_phase == 2));
    check("beat_cnt", W'(beat_cnt), W'(m_cnt));
    for (int i = 0; i < N; i++) if (req_rdy[i]) g_log.push_back(i);
    if (mem_dat_vld) n_vld++;
    if (tile_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N*W/32; i++) req_dat[i*32 +: 32] = $urandom;
  endtask

  task automatic start(input int num);
    cfg_start   = 1'b1;
    cfg_dat_num = LD'(num);
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_log(input int n, input string name);
    int c = 0;
    while (g_log.size() < n && c < 60) begin tick(); c++; end
    if (g_log.size() < n) timeout(name);
  endtask

  task automatic wait_done(input int target, input string name);
    int c = 0;
    while (n_done < target && c < 60) begin tick(); c++; end
    if (n_done < target) timeout(name);
    tick();
    tick();
  endtask

  function automatic int gl(input int i);
    return (i < g_log.size()) ? g_log[i] : -1;
  endfunction

  initial begin
    int base, v0, d0;
    int exp_rr[8];
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};

    repeat (3) tick();
    check("rst_rdy", W'(req_rdy), '0);
    check("rst_busy", W'(busy), '0);
    rst = 1'b0;
    tick();

    // Full tile, all requesters valid: strict rotation from pointer 0.
    req_vld = 4'hF; base = g_log.size(); v0 = n_vld; d0 = n_done;
    start(7);
    wait_done(d0 + 1, "t1_done");
    check("t1_ngrant", W'(g_log.size() - base), W'(8));
    for (int i = 0; i < 8; i++) check("t1_order", W'(gl(base + i)), W'(exp_rr[i]));
    check("t1_nvld", W'(n_vld - v0), W'(8));
    check("t1_ndone", W'(n_done - d0), W'(1));
    check("t1_beat_cnt", W'(beat_cnt), '0);

    // Single requester 2 owns the whole tile.
    req_vld = 4'b0100; base = g_log.size(); d0 = n_done;
    start(3);
    wait_done(d0 + 1, "t2_done");
    check("t2_ngrant", W'(g_log.size() - base), W'(4));
    for (int i = 0; i < 4; i++) check("t2_order", W'(gl(base + i)), W'(2));

    // Single-beat tile to requester 3, then pointer wraps to 0.
    req_vld = 4'b1000; base = g_log.size(); d0 = n_done;
    start(0);
    wait_done(d0 + 1, "t3_done");
    check("t3_grant", W'(gl(base)), W'(3));
    req_vld = 4'hF; base = g_log.size(); d0 = n_done;
    start(0);
    wait_done(d0 + 1, "t3b_done");
    check("t3b_grant", W'(gl(base)), W'(0));
    check("t3b_ngrant", W'(g_log.size() - base), W'(1));

    // Abort after two beats of six.
    base = g_log.size(); v0 = n_vld; d0 = n_done;
    start(5);
    wait_log(base + 2, "t4_grants");
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    repeat (4) tick();
    check("t4_ngrant", W'(g_log.size() - base), W'(2));
    check("t4_nvld", W'(n_vld - v0), W'(2));
    check("t4_ndone", W'(n_done - d0), '0);
    base = g_log.size(); d0 = n_done;
    start(1);
    wait_done(d0 + 1, "t4b_done");
    check("t4b_ngrant", W'(g_log.size() - base), W'(2));

    // cfg_start during RUN is ignored.
    base = g_log.size(); d0 = n_done;
    start(2);
    wait_log(base + 1, "t5_grants");
    cfg_start = 1'b1; cfg_dat_num = 3'd5;
    tick();
    cfg_start = 1'b0;
    wait_done(d0 + 1, "t5_done");
    check("t5_ngrant", W'(g_log.size() - base), W'(3));
    check("t5_num", W'(mem_dat_num), W'(2));

    // Reset in the middle of an 8-beat tile.
    base = g_log.size(); d0 = n_done;
    start(7);
    wait_log(base + 3, "t6_grants");
    #2 rst = 1'b1;
    tick();
    check("t6_rst_vld", W'(mem_dat_vld), '0);
    check("t6_rst_dat", mem_dat, '0);
    check("t6_rst_cnt", W'(beat_cnt), '0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_ndone", W'(n_done - d0), '0);
    check("t6_rdy", W'(req_rdy), '0);
    check("t6_busy", W'(busy), '0);

    // Random traffic, aborts and restarts, checked by the model every cycle.
    for (int c = 0; c < 500; c++) begin
      req_vld     = N'($urandom);
      cfg_start   = ($urandom_range(0, 3) == 0);
      cfg_dat_num = LD'($urandom);
      cfg_abort   = ($urandom_range(0, 29) == 0);
      tick();
    end
    cfg_start = 1'b0; cfg_abort = 1'b0; req_vld = '0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
